log_converter_pipe: RTL and testbench

- Forward Mitchell log converter for the approximate log multiplier datapath.
- Converts a 16-bit unsigned operand into the packed log word {k[3:0], x_t[FRAC_W-1:0]} that the multiplier adder and antilog stage consume.
- Two-stage elastic pipeline with valid/ready on both sides. One instance sits per operand, ahead of the log-domain adder.

---
 rtl/log_mult_pkg.sv | 19 +
 rtl/log_converter_pipe_lod.sv | 28 ++
 rtl/log_converter_pipe.sv | 139 +++++++++++++
 tb/tb_log_converter_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_mult_pkg.sv
// ---------------------------------------------------------------------------
// log_mult_pkg
// Shared definitions for the approximate (Mitchell) log multiplier datapath.
//   FRAC_W     : fraction width of x_t in the packed log word
//   log_word_t : packed log word {k[3:0], x_t[FRAC_W-1:0]}
//   LOG_ZERO   : log word emitted for a zero operand
// ---------------------------------------------------------------------------
package log_mult_pkg;

  localparam int FRAC_W = 8;

  typedef struct packed {
    logic [3:0]        k;
    logic [FRAC_W-1:0] x_t;
  } log_word_t;

  localparam log_word_t LOG_ZERO = '0;

endpackage : log_mult_pkg

// File: rtl/log_converter_pipe_lod.sv
// ---------------------------------------------------------------------------
// leading_one_detector
// Combinational 16-bit priority encoder for the log converter's first stage.
// Ports:
//   data : 16-bit unsigned operand
//   lead : index of the highest set bit (0 when data is 0)
//   zero : data == 0
// ---------------------------------------------------------------------------
module leading_one_detector
  import log_mult_pkg::*;
(
  input  logic [15:0] data,
  output logic [3:0]  lead,
  output logic        zero
);

  always_comb begin
    // NOTE: default assignment first so every path drives lead (no latch).
    lead = 4'd0;
    // Ascending scan: the last set bit seen is the most significant one.
    for (int i = 0; i < 16; i++) begin
      if (data[i]) lead = 4'(i);
    end
  end

  assign zero = (data == 16'h0000);

endmodule : leading_one_detector

// File: rtl/log_converter_pipe.sv
// ---------------------------------------------------------------------------
// log_converter_pipe
// Forward Mitchell log converter: 16-bit unsigned operand -> packed log word
// {k[3:0], x_t[FRAC_W-1:0]}. Two-stage elastic pipeline (LOD, normalise)
// with valid/ready handshakes on both sides; 2-cycle latency, 1 word/cycle.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : operand valid          in_ready  : operand accepted this cycle
//   in_data    : 16-bit operand
//   out_valid  : log word valid         out_ready : downstream takes the word
//   out_log    : {k, x_t}, k in [FRAC_W+3:FRAC_W]
//   out_zero   : operand was 0 (out_log forced to 0)
//
// Build option:
//   LOG_ROUND_EN : round x_t to nearest using the bit below the fraction;
//                  fraction overflow bumps k, k=15 overflow saturates to all
//                  ones. Undefined: x_t is plain truncation.
// ---------------------------------------------------------------------------
module log_converter_pipe #(
  parameter int FRAC_W = log_mult_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W+3:0] out_log,
  output logic              out_zero
);

  import log_mult_pkg::*;

  localparam int LOG_W = FRAC_W + 4;

  // Stage 1: registered operand plus leading-one information
  logic        s1_valid;
  logic [15:0] s1_data;
  logic [3:0]  s1_lead;
  logic        s1_zero;

  // Stage 2: finished log word
  logic             s2_valid;
  logic [LOG_W-1:0] s2_log;
  logic             s2_zero;

  logic s1_adv;
  logic s2_adv;

  logic [3:0] lod_lead;
  logic       lod_zero;

  logic [3:0]        nxt_k;
  logic [FRAC_W-1:0] nxt_x;

  // Ready depends only on registered valids and out_ready, never on in_valid.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  leading_one_detector u_lod (
    .data (in_data),
    .lead (lod_lead),
    .zero (lod_zero)
  );

  // ---------------- Stage 1: LOD ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers are not reset; s1_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_data <= in_data;
      s1_lead <= lod_lead;
      s1_zero <= lod_zero;
    end
  end

  // ---------------- Stage 2: normalise ----------------
  // The FRAC_W (+1 rounding) bits directly below the leading one are
  // bits [lead-1 -: ...] of the operand. Appending zeros below the operand
  // and shifting right by lead lands exactly that window at the bottom,
  // zero-filling whatever falls below bit 0 when lead is small.
`ifdef LOG_ROUND_EN
  logic [FRAC_W:0] norm;

  always_comb begin
    norm  = (FRAC_W+1)'({s1_data, {(FRAC_W+1){1'b0}}} >> s1_lead);
    nxt_k = s1_lead;
    nxt_x = norm[FRAC_W:1];
    if (norm[0]) begin
      if (&norm[FRAC_W:1]) begin
        // Fraction overflows into k; at k=15 hold the largest word instead.
        if (&s1_lead) begin
          nxt_x = '1;
        end else begin
          nxt_k = s1_lead + 4'd1;
          nxt_x = '0;
        end
      end else begin
        nxt_x = norm[FRAC_W:1] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    nxt_k = s1_lead;
    nxt_x = FRAC_W'({s1_data, {FRAC_W{1'b0}}} >> s1_lead);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_log   <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_log  <= s1_zero ? LOG_W'(LOG_ZERO) : {nxt_k, nxt_x};
        s2_zero <= s1_zero;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_log   = s2_log;
  assign out_zero  = s2_zero;

endmodule : log_converter_pipe

// File: tb/tb_log_converter_pipe.sv
// ---------------------------------------------------------------------------
// tb_log_converter_pipe
// Directed and random stimulus for log_converter_pipe (FRAC_W = 8).
// Inputs change 1 time unit after the rising edge; outputs and handshakes
// are observed on the falling edge, i.e. what the next rising edge will see.
// Define LOG_ROUND_EN for both bench and RTL to cover the rounding build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_log_converter_pipe;

  localparam int FRAC_W = 8;
  localparam int LW     = FRAC_W + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_log;
  logic          out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Stream bookkeeping: expected words {zero, log} in acceptance order
  logic [LW:0]   exp_q[$];
  int            occ;
  logic          stall_prev;
  logic [LW-1:0] held_log;
  logic          held_zero;
  logic          saw_not_ready;
  int            n_emit;

  log_converter_pipe #(.FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_log   (out_log),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference converter written from the arithmetic definition:
  // fraction = bits of d below its leading one, scaled to FRAC_W bits.
  function automatic logic [LW:0] log_model(input logic [15:0] d);
    int                lead;
    logic [3:0]        k;
    logic [FRAC_W-1:0] x;
    if (d == 16'h0000) return {1'b1, {LW{1'b0}}};
    lead = 0;
    for (int i = 0; i < 16; i++) if (d[i]) lead = i;
    if (lead >= FRAC_W) x = FRAC_W'(d >> (lead - FRAC_W));
    else                x = FRAC_W'(d << (FRAC_W - lead));
    k = 4'(lead);
`ifdef LOG_ROUND_EN
    if (lead > FRAC_W && d[lead-FRAC_W-1]) begin
      if (x == '1) begin
        if (k != 4'd15) begin
          k = k + 4'd1;
          x = '0;
        end
      end else begin
        x = x + 1'b1;
      end
    end
`endif
    return {1'b0, k, x};
  endfunction

  task automatic clear_stream();
    exp_q.delete();
    occ           = 0;
    stall_prev    = 1'b0;
    held_log      = '0;
    held_zero     = 1'b0;
    saw_not_ready = 1'b0;
    n_emit        = 0;
  endtask

  // One clock of a streaming scenario: drive, then at the falling edge
  // check ready, stall stability and any emitted word against exp_q.
  task automatic stream_cycle(input logic iv, input logic [15:0] d,
                              input logic [LW:0] exp_word, input logic ordy,
                              output logic acc);
    logic        exp_rdy;
    logic        emit;
    logic [LW:0] e;
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = (occ < 2) || ordy;
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL stream_in_ready: got %b expected %b (occupancy %0d)", in_ready, exp_rdy, occ);
    end
    if (in_ready === 1'b0) saw_not_ready = 1'b1;
    if (stall_prev) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_log !== held_log || out_zero !== held_zero) begin
        n_fail++;
        $display("FAIL stall_stable: got v=%b log=%h z=%b expected v=1 log=%h z=%b",
                 out_valid, out_log, out_zero, held_log, held_zero);
      end
    end
    acc  = iv && (in_ready === 1'b1);
    emit = (out_valid === 1'b1) && ordy;
    if (emit) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_spurious: got log=%h with no word outstanding", out_log);
      end else begin
        e = exp_q.pop_front();
        n_emit++;
        if (out_log !== e[LW-1:0] || out_zero !== e[LW]) begin
          n_fail++;
          $display("FAIL stream_data: got log=%h z=%b expected log=%h z=%b",
                   out_log, out_zero, e[LW-1:0], e[LW]);
        end
      end
    end
    if (acc) exp_q.push_back(exp_word);
    occ        = occ + (acc ? 1 : 0) - (emit ? 1 : 0);
    stall_prev = (out_valid === 1'b1) && !ordy;
    held_log   = out_log;
    held_zero  = out_zero;
  endtask

  // Single word through an empty pipe with out_ready=1; checks latency.
  task automatic send_one(input logic [15:0] d, input logic [LW-1:0] exp_log,
                          input logic exp_zero, input string name);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready got %b expected 1", name, in_ready);
    end
    @(posedge clk);                     // edge N: accepted
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: out_valid got %b expected 0 after accept edge", name, out_valid);
    end
    @(posedge clk);                     // edge N+1
    @(negedge clk);                     // word presented, taken at edge N+2
    n_checks++;
    if (out_valid !== 1'b1 || out_log !== exp_log || out_zero !== exp_zero) begin
      n_fail++;
      $display("FAIL %s: got v=%b log=%h z=%b expected v=1 log=%h z=%b",
               name, out_valid, out_log, out_zero, exp_log, exp_zero);
    end
    @(posedge clk);                     // edge N+2: consumed
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_dup: out_valid got %b expected 0 after transfer", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_log !== '0 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b log=%h z=%b rdy=%b expected v=0 log=000 z=0 rdy=1",
               out_valid, out_log, out_zero, in_ready);
    end
  endtask

  task automatic test_basic();
    send_one(16'h0001, 12'h000, 1'b0, "one");
    send_one(16'h8000, 12'hF00, 1'b0, "msb");
    send_one(16'h00B4, 12'h768, 1'b0, "b4");
    send_one(16'h0000, 12'h000, 1'b1, "zero");
  endtask

  task automatic test_round_boundary();
`ifdef LOG_ROUND_EN
    send_one(16'h03FF, 12'hA00, 1'b0, "3ff_round");
`else
    send_one(16'h03FF, 12'h9FF, 1'b0, "3ff_trunc");
`endif
    send_one(16'hFFFF, 12'hFFF, 1'b0, "ffff_sat");
  endtask

  task automatic test_back_to_back();
    logic [15:0]   tbl_d[6]   = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    logic [LW-1:0] tbl_log[6] = '{12'h000, 12'h100, 12'h180, 12'h200, 12'h240, 12'h280};
    int   idx = 0;
    logic acc;
    clear_stream();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx == 6 && occ == 0) break;
      stream_cycle(idx < 6, (idx < 6) ? tbl_d[idx] : 16'h0000,
                   {1'b0, (idx < 6) ? tbl_log[idx] : 12'h000},
                   !(cyc >= 2 && cyc <= 5), acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_emit !== 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words out (%0d pending) expected 6", n_emit, exp_q.size());
    end
    n_checks++;
    if (saw_not_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_backpressure: in_ready never dropped, expected 0 with pipe full and stalled");
    end
  endtask

  task automatic test_random();
    int          words = 0;
    logic        acc;
    logic        iv;
    logic        ordy;
    logic [15:0] d;
    clear_stream();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (words >= 1000 && occ == 0) break;
      case ($urandom_range(0, 7))
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        2:       d = 16'(1) << $urandom_range(0, 15);
        3:       d = 16'($urandom_range(0, 511));
        default: d = 16'($urandom);
      endcase
      iv   = (words < 1000) && ($urandom_range(0, 3) != 0);
      ordy = (words >= 1000) || ($urandom_range(0, 3) != 0);
      stream_cycle(iv, d, log_model(d), ordy, acc);
      if (acc) words++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_emit !== 1000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_count: got %0d words out (%0d pending) expected 1000", n_emit, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = 16'h0010;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_data = 16'h0020;
    @(posedge clk);                     // two words now in flight
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_log !== '0) begin
      n_fail++;
      $display("FAIL midflight_reset: got v=%b rdy=%b log=%h expected v=0 rdy=1 log=000",
               out_valid, in_ready, out_log);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_flush: out_valid got %b expected 0", out_valid);
    end
    send_one(16'h00B4, 12'h768, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_boundary();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_log_converter_pipe
